// File: rtl/layer_line_sequencer_if.sv
// Signal bundle between the line sequencer and its surroundings: video timing,
// the layer renderer and the line buffer write port.
interface layer_line_sequencer_if;
  logic       line_start;
  logic       frame_start;
  logic [9:0] line_width;
  logic       render_start;
  logic [9:0] render_line;
  logic       render_done;
  logic [9:0] rnd_wr_idx;
  logic [7:0] rnd_wr_data;
  logic       rnd_wr_en;
  logic [9:0] lb_wr_idx;
  logic [7:0] lb_wr_data;
  logic       lb_wr_en;
  logic       lb_active_render_buffer;
  logic       composer_line_valid;
  logic       overrun;
  logic [7:0] overrun_count;

  modport master (
    input  line_start, frame_start, line_width, render_done,
           rnd_wr_idx, rnd_wr_data, rnd_wr_en,
    output render_start, render_line, lb_wr_idx, lb_wr_data, lb_wr_en,
           lb_active_render_buffer, composer_line_valid, overrun, overrun_count
  );

  modport slave (
    output line_start, frame_start, line_width, render_done,
           rnd_wr_idx, rnd_wr_data, rnd_wr_en,
    input  render_start, render_line, lb_wr_idx, lb_wr_data, lb_wr_en,
           lb_active_render_buffer, composer_line_valid, overrun, overrun_count
  );
endinterface

// File: rtl/layer_line_sequencer.sv
// Double-buffered line sequencer: swaps halves on line_start, zero-fills the new
// render half, then passes the write port to the renderer until render_done.
module layer_line_sequencer #(
  parameter int MAX_WIDTH = 768,
  parameter bit CLEAR_EN  = 1'b1
) (
  input logic                    clk,
  input logic                    rst_n,
  layer_line_sequencer_if.master bus
);

  typedef enum logic [1:0] {IDLE, CLEAR, RENDER, DONE} state_t;

  localparam logic [9:0] MAX_W = 10'(MAX_WIDTH);

  state_t     state;
  logic [9:0] width;
  logic [9:0] clr_idx;
  logic       sel;
  logic [9:0] line;
  logic       line_valid;
  logic       start_pulse;
  logic       overrun_pulse;
  logic [7:0] overrun_cnt;
  logic [9:0] width_new;
  logic       busy;

  assign width_new = (bus.line_width > MAX_W) ? MAX_W : bus.line_width;
  assign busy      = (state == CLEAR) || (state == RENDER);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      width         <= '0;
      clr_idx       <= '0;
      sel           <= 1'b0;
      line          <= '0;
      line_valid    <= 1'b0;
      start_pulse   <= 1'b0;
      overrun_pulse <= 1'b0;
      overrun_cnt   <= '0;
    end else begin
      start_pulse   <= 1'b0;
      overrun_pulse <= 1'b0;
      if (bus.line_start) begin
        // A swap overrides whatever the current line was doing.
        sel           <= ~sel;
        width         <= width_new;
        clr_idx       <= '0;
        line_valid    <= (state == DONE);
        line          <= bus.frame_start ? '0 : line + 10'd1;
        overrun_pulse <= busy;
        if (!CLEAR_EN || width_new == '0) begin
          state       <= RENDER;
          start_pulse <= 1'b1;
        end else begin
          state <= CLEAR;
        end
      end else begin
        case (state)
          CLEAR: begin
            if (clr_idx == width - 10'd1) begin
              state       <= RENDER;
              start_pulse <= 1'b1;
            end else begin
              clr_idx <= clr_idx + 10'd1;
            end
          end
          RENDER: if (bus.render_done) state <= DONE;
          default: ;
        endcase
      end

      // Frame start restarts the count, keeping only this cycle's overrun.
      if (bus.frame_start)
        overrun_cnt <= {7'd0, bus.line_start & busy};
      else if (bus.line_start && busy && overrun_cnt != 8'hFF)
        overrun_cnt <= overrun_cnt + 8'd1;
    end
  end

  always_comb begin
    bus.lb_wr_en   = 1'b0;
    bus.lb_wr_idx  = '0;
    bus.lb_wr_data = '0;
    case (state)
      CLEAR: begin
        bus.lb_wr_en  = 1'b1;
        bus.lb_wr_idx = clr_idx;
      end
      RENDER: begin
        bus.lb_wr_en   = bus.rnd_wr_en && (bus.rnd_wr_idx < width);
        bus.lb_wr_idx  = bus.rnd_wr_idx;
        bus.lb_wr_data = bus.rnd_wr_data;
      end
      default: ;
    endcase
  end

  assign bus.render_start            = start_pulse;
  assign bus.render_line             = line;
  assign bus.lb_active_render_buffer = sel;
  assign bus.composer_line_valid     = line_valid;
  assign bus.overrun                 = overrun_pulse;
  assign bus.overrun_count           = overrun_cnt;

endmodule
